// File: rtl/regex_memory_arbiter.sv
// Round-robin arbiter sharing one single-port instruction BRAM among several regex CPUs.
// One grant per cycle; BRAM words are broadcast and held until the next grant's data cycle.
module regex_memory_arbiter #(
  parameter int unsigned CPU_COUNT         = 4,
  parameter int unsigned MEMORY_WIDTH      = 20,
  parameter int unsigned MEMORY_ADDR_WIDTH = 11
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [CPU_COUNT-1:0]                   cpu_memory_valid,
  input  logic [CPU_COUNT*MEMORY_ADDR_WIDTH-1:0] cpu_memory_addr,
  output logic [CPU_COUNT-1:0]                   cpu_memory_ready,
  output logic [MEMORY_WIDTH-1:0]                cpu_memory_data,
  output logic                                   mem_en,
  output logic [MEMORY_ADDR_WIDTH-1:0]           mem_addr,
  input  logic [MEMORY_WIDTH-1:0]                mem_rdata
);

  localparam int unsigned PTR_W = (CPU_COUNT > 1) ? $clog2(CPU_COUNT) : 1;

  logic [PTR_W-1:0]             rr_ptr;
  logic                         data_pending;
  logic [MEMORY_WIDTH-1:0]      data_hold;

  logic [CPU_COUNT-1:0]         eligible;
  logic                         grant_found;
  logic [PTR_W-1:0]             grant_idx;
  logic [PTR_W-1:0]             next_ptr;
  logic [CPU_COUNT-1:0]         grant_vec;
  logic [MEMORY_ADDR_WIDTH-1:0] sel_addr;
  int unsigned                  cand;

  // The ready register doubles as the cooldown mask: a CPU granted this cycle is not eligible at the next edge.
  always_comb begin
    eligible    = cpu_memory_valid & ~cpu_memory_ready;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned i = 0; i < CPU_COUNT; i++) begin
      cand = 32'(rr_ptr) + i;
      if (cand >= CPU_COUNT) cand = cand - CPU_COUNT;
      if (!grant_found && eligible[PTR_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(cand);
      end
    end
  end

  always_comb begin
    next_ptr  = (grant_idx == PTR_W'(CPU_COUNT - 1)) ? '0 : grant_idx + PTR_W'(1);
    grant_vec = grant_found ? (CPU_COUNT'(1) << grant_idx) : '0;
    sel_addr  = cpu_memory_addr[32'(grant_idx)*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
  end

  // Grant, BRAM request and round-robin state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_memory_ready <= '0;
      mem_en           <= 1'b0;
      mem_addr         <= '0;
      rr_ptr           <= '0;
    end else begin
      cpu_memory_ready <= grant_vec;
      mem_en           <= grant_found;
      if (grant_found) begin
        mem_addr <= sel_addr;
        rr_ptr   <= next_ptr;
      end
    end
  end

  // Word arrives the cycle after mem_en; latch it so the bus stays stable until the next fetch lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_pending <= 1'b0;
      data_hold    <= '0;
    end else begin
      data_pending <= mem_en;
      if (data_pending) data_hold <= mem_rdata;
    end
  end

  assign cpu_memory_data = data_pending ? mem_rdata : data_hold;

endmodule

// File: tb/tb_regex_memory_arbiter.sv
// Directed and randomized-traffic checks for regex_memory_arbiter against a behavioural BRAM.
module tb_regex_memory_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 20;
  localparam int unsigned AW = 11;
  localparam int unsigned DEPTH = 2048;

  logic            clk;
  logic            rst;
  logic [N-1:0]    cpu_memory_valid;
  logic [N*AW-1:0] cpu_memory_addr;
  logic [N-1:0]    cpu_memory_ready;
  logic [DW-1:0]   cpu_memory_data;
  logic            mem_en;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_rdata;

  logic [DW-1:0]   bram [DEPTH];

  int tests_run;
  int tests_failed;

  regex_memory_arbiter #(.CPU_COUNT(N), .MEMORY_WIDTH(DW), .MEMORY_ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .rst              (rst),
    .cpu_memory_valid (cpu_memory_valid),
    .cpu_memory_addr  (cpu_memory_addr),
    .cpu_memory_ready (cpu_memory_ready),
    .cpu_memory_data  (cpu_memory_data),
    .mem_en           (mem_en),
    .mem_addr         (mem_addr),
    .mem_rdata        (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem_rdata <= bram[mem_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int unsigned i, input logic [AW-1:0] a);
    cpu_memory_addr[i*AW +: AW] = a;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  logic [AW-1:0] req_addr [N];
  logic          pend;
  logic [AW-1:0] pend_addr;
  logic [N-1:0]  g;
  logic          any_act;
  int            k;
  int            cnt;
  int            cycles;
  int            others;

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b0;
    cpu_memory_valid = '0;
    cpu_memory_addr = '0;
    mem_rdata = '0;
    for (int i = 0; i < DEPTH; i++) bram[i] = DW'($urandom);
    bram[11'h05A] = 20'hABCDE;
    for (int i = 0; i < 4; i++) bram[11'h010 + i] = 20'h11110 + DW'(i);
    bram[11'h100] = 20'h12345;
    bram[11'h200] = 20'h54321;
    bram[11'h300] = 20'h0F0F0;
    #3;
    repeat (2) tick();
    rst = 1'b1;

    // Reset values
    check_eq("rst_ready", 32'(cpu_memory_ready), 32'h0);
    check_eq("rst_mem_en", 32'(mem_en), 32'h0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'h0);
    check_eq("rst_data", 32'(cpu_memory_data), 32'h0);

    // Single request from CPU 2
    set_addr(2, 11'h05A);
    cpu_memory_valid = 4'b0100;
    tick();
    check_eq("single_ready", 32'(cpu_memory_ready), 32'h4);
    check_eq("single_en", 32'(mem_en), 32'h1);
    check_eq("single_addr", 32'(mem_addr), 32'h05A);
    cpu_memory_valid = '0;
    tick();
    check_eq("single_ready_off", 32'(cpu_memory_ready), 32'h0);
    check_eq("single_data", 32'(cpu_memory_data), 32'hABCDE);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("single_hold", 32'(cpu_memory_data), 32'hABCDE);
      check_eq("single_idle", 32'(cpu_memory_ready), 32'h0);
    end

    // All four request together right after reset
    do_reset();
    for (int i = 0; i < 4; i++) set_addr(i, 11'h010 + AW'(i));
    cpu_memory_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i < 4) begin
        check_eq("all_ready", 32'(cpu_memory_ready), 32'(1) << i);
        check_eq("all_addr", 32'(mem_addr), 32'h010 + 32'(i));
      end else begin
        check_eq("all_ready_end", 32'(cpu_memory_ready), 32'h0);
      end
      if (i > 0) check_eq("all_data", 32'(cpu_memory_data), 32'h11110 + 32'(i - 1));
      cpu_memory_valid = cpu_memory_valid & ~cpu_memory_ready;
    end

    // Pointer wrapped to 0 after CPU 3: CPU 0 beats CPU 3
    set_addr(0, 11'h100);
    set_addr(3, 11'h300);
    cpu_memory_valid = 4'b1001;
    tick();
    check_eq("wrap_first", 32'(cpu_memory_ready), 32'h1);
    cpu_memory_valid = cpu_memory_valid & ~cpu_memory_ready;
    tick();
    check_eq("wrap_second", 32'(cpu_memory_ready), 32'h8);
    check_eq("wrap_second_addr", 32'(mem_addr), 32'h300);
    check_eq("wrap_data0", 32'(cpu_memory_data), 32'h12345);
    cpu_memory_valid = '0;
    tick();
    check_eq("wrap_data3", 32'(cpu_memory_data), 32'h0F0F0);

    // Lone CPU holding valid is granted on alternate cycles only
    set_addr(1, 11'h100);
    cpu_memory_valid = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("cool_ready", 32'(cpu_memory_ready), (i % 2 == 0) ? 32'h2 : 32'h0);
    end
    cpu_memory_valid = '0;
    repeat (2) tick();
    check_eq("cool_data", 32'(cpu_memory_data), 32'h12345);

    // Reset asserted during a grant cycle
    set_addr(0, 11'h200);
    cpu_memory_valid = 4'b0001;
    tick();
    cpu_memory_valid = '0;
    check_eq("mid_grant", 32'(cpu_memory_ready), 32'h1);
    check_eq("mid_data_pre", 32'(cpu_memory_data), 32'h12345);
    #1 rst = 1'b0;
    #1;
    check_eq("mid_ready", 32'(cpu_memory_ready), 32'h0);
    check_eq("mid_en", 32'(mem_en), 32'h0);
    check_eq("mid_data", 32'(cpu_memory_data), 32'h0);
    tick();
    rst = 1'b1;
    any_act = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      any_act = any_act | (|cpu_memory_ready) | mem_en;
    end
    check_eq("post_rst_idle", 32'(any_act), 32'h0);
    check_eq("post_rst_data", 32'(cpu_memory_data), 32'h0);
    set_addr(3, 11'h05A);
    cpu_memory_valid = 4'b1000;
    tick();
    cpu_memory_valid = '0;
    check_eq("post_rst_grant", 32'(cpu_memory_ready), 32'h8);
    tick();
    check_eq("post_rst_word", 32'(cpu_memory_data), 32'hABCDE);

    // Sweep: each CPU fetches every address against random competing traffic
    do_reset();
    for (int i = 0; i < DEPTH; i++) bram[i] = DW'($urandom);
    pend = 1'b0;
    pend_addr = '0;
    for (int t = 0; t < N; t++) begin
      cnt = 0;
      cycles = 0;
      others = 0;
      req_addr[t] = '0;
      set_addr(t, '0);
      cpu_memory_valid[t] = 1'b1;
      while (cnt < DEPTH && cycles < DEPTH * 10) begin
        tick();
        cycles++;
        if (pend) check_eq("sweep_data", 32'(cpu_memory_data), 32'(bram[pend_addr]));
        pend = 1'b0;
        g = cpu_memory_ready;
        if (g != '0) begin
          check_eq("sweep_onehot", 32'($countones(g)), 32'h1);
          k = 0;
          for (int j = N - 1; j >= 0; j--) if (g[j]) k = j;
          check_eq("sweep_en", 32'(mem_en), 32'h1);
          check_eq("sweep_addr", 32'(mem_addr), 32'(req_addr[k]));
          pend = 1'b1;
          pend_addr = req_addr[k];
          cpu_memory_valid[k] = 1'b0;
          if (k == t) begin
            check_eq("sweep_starve", 32'(others <= N - 1), 32'h1);
            others = 0;
            cnt++;
            if (cnt < DEPTH) begin
              req_addr[t] = AW'(cnt);
              set_addr(t, AW'(cnt));
              cpu_memory_valid[t] = 1'b1;
            end
          end else begin
            others++;
          end
        end else begin
          check_eq("sweep_en_idle", 32'(mem_en), 32'h0);
        end
        for (int j = 0; j < N; j++) begin
          if (j != t && !cpu_memory_valid[j] && ($urandom_range(1, 0) == 1)) begin
            req_addr[j] = AW'($urandom);
            set_addr(j, req_addr[j]);
            cpu_memory_valid[j] = 1'b1;
          end
        end
      end
      check_eq("sweep_done", 32'(cnt), 32'(DEPTH));
    end
    cpu_memory_valid = '0;
    tick();
    if (pend) check_eq("sweep_data_last", 32'(cpu_memory_data), 32'(bram[pend_addr]));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/regex_memory_arbiter.md
# regex_memory_arbiter

Shares one single-port instruction BRAM among `CPU_COUNT` `regex_cpu` instances; sits directly on the instruction-fetch side of each CPU, answering its `memory_valid`/`memory_addr` request with a one-cycle `memory_ready` grant followed by the instruction word. Arbitration is round-robin, one grant per cycle, with the BRAM read pipelined so back-to-back grants to different CPUs sustain one fetch per cycle. Instruction words are broadcast on a shared data bus; only the granted CPU consumes them.

## Interface
- `CPU_COUNT`, 4, number of attached CPUs (≥2, power of two not required)
- `MEMORY_WIDTH`, 20, instruction word width
- `MEMORY_ADDR_WIDTH`, 11, instruction address width
- `clk`  input  1  single clock, all logic on rising edge
- `rst`  input  1  one clock; reset is asynchronous and active-low
- `cpu_memory_valid`  input  CPU_COUNT  bit i: CPU i requests a fetch; held high until its grant
- `cpu_memory_addr`  input  CPU_COUNT*MEMORY_ADDR_WIDTH  slice i = CPU i fetch address
- `cpu_memory_ready`  output  CPU_COUNT  one-hot grant pulse, one cycle
- `cpu_memory_data`  output  MEMORY_WIDTH  broadcast instruction word
- `mem_en`  output  1  BRAM read enable
- `mem_addr`  output  MEMORY_ADDR_WIDTH  BRAM read address
- `mem_rdata`  input  MEMORY_WIDTH  BRAM output, valid the cycle after `mem_en`

## Operation
- Eligible set = `cpu_memory_valid` AND NOT `cooldown`; `cooldown` = one-hot of the CPU granted in the current cycle (a CPU's valid may still be high the cycle after its grant; it must not be re-granted then).
- Round-robin pointer `rr_ptr` (width clog2(CPU_COUNT)): search starts at `rr_ptr`, wraps modulo CPU_COUNT; first eligible index wins. After a grant to index k, `rr_ptr` ← (k+1) mod CPU_COUNT. No grant → pointer unchanged.
- Grant register: winner registered at the edge; `cpu_memory_ready[k]`, `mem_en`=1 and `mem_addr` = slice k of `cpu_memory_addr` (captured at the same edge) all driven from registers during the grant cycle.
- `data_pending` flag registered from `mem_en`; when set, `cpu_memory_data` = `mem_rdata` and `mem_rdata` is copied into `data_hold` at the end of that cycle; otherwise `cpu_memory_data` = `data_hold`.
- Requests whose valid drops before grant are simply no longer eligible (protocol violation by CPU, not flagged).

## Timing
- Reset values: `cpu_memory_ready`=0, `mem_en`=0, `mem_addr`=0, `cpu_memory_data`=0 (`data_hold`=0, `data_pending`=0), `rr_ptr`=0, `cooldown`=0.
- Request high during cycle T−1 → sampled at edge E → `cpu_memory_ready[k]`, `mem_en`, `mem_addr` high/valid during T (grant latency 1 cycle from first visible request).
- Word for that grant on `cpu_memory_data` during T+1; held stable until the next grant's T+1 cycle.
- Throughput: one grant per cycle when ≥2 distinct CPUs request; a lone CPU is granted at most every other cycle (cooldown), but a CPU re-raising valid after cooldown is granted immediately.
- Simultaneous requests: resolved purely by `rr_ptr` order; starvation bound = CPU_COUNT−1 grants.
- Reset asserted mid-operation: all outputs return to reset values asynchronously; an in-flight word is discarded; no grant issued on the first edge after deassertion unless a request is present in that cycle.

## Test plan
- Single request: CPU 2 valid, addr 0x05A, BRAM word at 0x05A = 0xABCDE -> `cpu_memory_ready`=4'b0100 for exactly one cycle, `mem_addr`=0x05A that cycle, `cpu_memory_data`=0xABCDE next cycle and held 10 cycles after.
- All four CPUs request together after reset (addrs 0x010..0x013) -> grants in order 0,1,2,3 on four consecutive cycles, data 0x010..0x013 contents each following cycle; no idle cycle.
- rr_ptr wrap: after grant to CPU 3, CPUs 0 and 3 request -> CPU 0 granted first, then CPU 3.
- Cooldown: CPU 1 holds valid continuously for 6 cycles -> `cpu_memory_ready[1]` pulses on alternate cycles only, never two consecutive cycles.
- Reset mid-fetch: assert `rst`=0 during a grant cycle -> ready, `mem_en`, `cpu_memory_data` go 0 immediately; after release with no requests, no grant for 20 cycles.
- Sweep: each CPU in turn fetches all 2048 addresses with random BRAM contents under random competing traffic -> every grant returns the word at the granted address, grants strictly one-hot.
